// File: rtl/uart_pkg.sv
`default_nettype none
// ======================================================================
// uart_pkg: shared UART states, line levels and frame helpers. Rev 1.0
// ======================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic c_LINE_IDLE  = 1'b1;
   localparam logic c_LINE_START = 1'b0;

   // Baud ticks occupied by one complete frame.
   function automatic int unsigned frame_ticks(input int unsigned data_width,
                                               input int unsigned oversample,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
      return (1 + data_width + parity_en + stop_bits) * oversample;
   endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_counter.sv
`default_nettype none
// ======================================================================
// baud_tick_counter: modulo-OVERSAMPLE tick counter with bit_end. Rev 1.0
// ======================================================================
module baud_tick_counter #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic tick_i,
   output logic bit_end_o
);

   localparam int              CW     = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]   c_LAST = CW'(OVERSAMPLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end_o = tick_i && (cnt_q == c_LAST);

   // Clear wins over a coincident tick so a new bit always starts at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ======================================================================
// uart_tx_ctrl: UART transmit sequencer driving an external shifter. Rev 1.0
// ======================================================================
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int   DATA_WIDTH = 8,
   parameter int   OVERSAMPLE = 16,
   parameter logic PARITY_EN  = 1'b0,
   parameter logic PARITY_ODD = 1'b0,
   parameter int   STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  tx,
   output logic                  sr_load,
   output logic                  sr_shift,
   output logic [DATA_WIDTH-1:0] sr_data_p,
   output logic                  sr_data_in_s,
   input  logic                  sr_data_out_s
);

   localparam int              BCW         = $clog2(DATA_WIDTH + 1);
   localparam logic [BCW-1:0]  c_LAST_DATA = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]  c_LAST_STOP = BCW'(STOP_BITS - 1);

   tx_state_t      state_q;
   tx_state_t      state_d;
   logic [BCW-1:0] bit_cnt_q;
   logic [BCW-1:0] bit_cnt_d;
   logic           parity_q;
   logic           parity_d;

   logic           w_accept;
   logic           w_tick_en;
   logic           w_bit_end;
   logic           w_shift;

   assign tx_ready     = (state_q == IDLE);
   assign busy         = !tx_ready;
   assign w_accept     = tx_valid && tx_ready && !rst;
   assign sr_load      = w_accept;
   assign sr_data_p    = tx_data;
   assign sr_data_in_s = 1'b1;
   assign sr_shift     = w_shift;

   // Ticks are only counted inside a frame, so a tick in the accept cycle is dropped.
   assign w_tick_en = baud_tick && (state_q != IDLE);

   baud_tick_counter #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_tick_cnt (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (w_accept),
      .tick_i    (w_tick_en),
      .bit_end_o (w_bit_end)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      w_shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (w_accept) begin
               state_d   = START;
               bit_cnt_d = '0;
               parity_d  = (^tx_data) ^ PARITY_ODD;
            end
         end
         START: begin
            if (w_bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift = 1'b1;
               if (bit_cnt_q == c_LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (bit_cnt_q == c_LAST_STOP) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
      end
   end

   // Line level is a pure mux of the registered state.
   always_comb begin
      tx = c_LINE_IDLE;
      case (state_q)
         IDLE:    tx = c_LINE_IDLE;
         START:   tx = c_LINE_START;
         DATA:    tx = sr_data_out_s;
         PARITY:  tx = parity_q;
         STOP:    tx = c_LINE_IDLE;
         default: tx = c_LINE_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ======================================================================
// tb_uart_tx_ctrl: three-configuration bench with a frame-level model. Rev 1.0
// ======================================================================
module tb_uart_tx_ctrl;
   import uart_pkg::*;

   localparam int OS = 4;
   localparam int CFG_PE  [3] = '{0, 1, 1};
   localparam int CFG_ODD [3] = '{0, 0, 1};
   localparam int CFG_ST  [3] = '{1, 2, 1};

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic       tx_valid;

   logic [2:0] rdy_w, busy_w, tx_w, load_w, shift_w, fill_w, sr_out;
   logic [7:0] sr_p [3];
   logic [7:0] sr_q [3];

   int n_cmp = 0;
   int n_bad = 0;

   // frame-level reference model: expected line bits and ticks elapsed
   bit          m_busy  [3];
   int          m_ticks [3];
   int          m_nbits [3];
   logic [15:0] m_bits  [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0),
                  .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(rdy_w[0]), .busy(busy_w[0]), .tx(tx_w[0]),
      .sr_load(load_w[0]), .sr_shift(shift_w[0]), .sr_data_p(sr_p[0]),
      .sr_data_in_s(fill_w[0]), .sr_data_out_s(sr_out[0]));

   uart_tx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1),
                  .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(rdy_w[1]), .busy(busy_w[1]), .tx(tx_w[1]),
      .sr_load(load_w[1]), .sr_shift(shift_w[1]), .sr_data_p(sr_p[1]),
      .sr_data_in_s(fill_w[1]), .sr_data_out_s(sr_out[1]));

   uart_tx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1),
                  .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(rdy_w[2]), .busy(busy_w[2]), .tx(tx_w[2]),
      .sr_load(load_w[2]), .sr_shift(shift_w[2]), .sr_data_p(sr_p[2]),
      .sr_data_in_s(fill_w[2]), .sr_data_out_s(sr_out[2]));

   // external right-shifting shift registers, LSB out
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (load_w[i])       sr_q[i] <= sr_p[i];
         else if (shift_w[i]) sr_q[i] <= {fill_w[i], sr_q[i][7:1]};
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) sr_out[i] = sr_q[i][0];
   end

   task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s[dut%0d] observed=%0h expected=%0h at %0t", tag, i, obs, exp, $time);
      end
   endtask

   function automatic bit any_busy();
      return m_busy[0] || m_busy[1] || m_busy[2];
   endfunction

   function automatic bit all_busy();
      return m_busy[0] && m_busy[1] && m_busy[2];
   endfunction

   task automatic cyc(input logic v, input logic [7:0] d, input logic bt, input logic r);
      logic e_tx, e_load, e_shift;
      int   bidx;
      logic [15:0] b;
      tx_valid  = v;
      tx_data   = d;
      baud_tick = bt;
      rst       = r;
      #1;
      for (int i = 0; i < 3; i++) begin
         bidx    = m_ticks[i] / OS;
         e_tx    = m_busy[i] ? m_bits[i][bidx] : 1'b1;
         e_load  = v && !m_busy[i] && !r;
         e_shift = m_busy[i] && bt && (m_ticks[i] % OS == OS - 1) && bidx >= 1 && bidx <= 8;
         chk("tx", i, {7'd0, tx_w[i]}, {7'd0, e_tx});
         chk("tx_ready", i, {7'd0, rdy_w[i]}, {7'd0, !m_busy[i]});
         chk("busy", i, {7'd0, busy_w[i]}, {7'd0, m_busy[i]});
         chk("sr_load", i, {7'd0, load_w[i]}, {7'd0, e_load});
         chk("sr_shift", i, {7'd0, shift_w[i]}, {7'd0, e_shift});
         if (e_load) chk("sr_data_p", i, sr_p[i], d);
      end
      for (int i = 0; i < 3; i++) begin
         if (r) begin
            m_busy[i] = 1'b0;
         end else if (!m_busy[i] && v) begin
            b = '1;
            b[0] = 1'b0;
            b[8:1] = d;
            if (CFG_PE[i] != 0) b[9] = (^d) ^ (CFG_ODD[i] != 0);
            m_bits[i]  = b;
            m_nbits[i] = 9 + CFG_PE[i] + CFG_ST[i];
            m_ticks[i] = 0;
            m_busy[i]  = 1'b1;
         end else if (m_busy[i] && bt) begin
            m_ticks[i]++;
            if (m_ticks[i] == m_nbits[i] * OS) m_busy[i] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // runs until every model is idle; noise toggles valid/data only while all are busy
   task automatic drain(input int period, input int phase, input bit noise);
      int k = 1;
      int bound;
      bound = int'(frame_ticks(8, OS, 1, 2)) * period + 20;
      while (any_busy() && k < bound) begin
         cyc(noise && all_busy() && ($urandom_range(1) == 1), 8'($urandom),
             ((k + phase) % period) == 0, 1'b0);
         k++;
      end
      n_cmp++;
      assert (!any_busy()) else begin
         n_bad++;
         $error("FAIL drain_timeout observed=busy expected=idle within %0d cycles", bound);
      end
   endtask

   task automatic frame(input logic [7:0] d, input int period, input int phase, input bit noise);
      cyc(1'b1, d, (phase % period) == 0, 1'b0);
      drain(period, phase, noise);
      cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; baud_tick = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 1'b0; m_ticks[i] = 0; m_nbits[i] = 10; m_bits[i] = '1;
      end
      repeat (2) @(posedge clk);
      #1;
      cyc(1'b1, 8'h5A, 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);

      frame(8'hA5, 1, 0, 1'b0);
      frame(8'h01, 1, 0, 1'b0);
      frame(8'hFF, 1, 0, 1'b0);
      frame(8'hA5, 3, 0, 1'b0);
      frame(8'h3C, 3, 1, 1'b0);

      for (int k = 0; k < 150; k++) cyc(1'b1, (k < 80) ? 8'hFF : 8'($urandom), 1'b1, 1'b0);
      drain(1, 0, 1'b0);

      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      for (int k = 0; k < 14; k++) cyc(1'b0, 8'h3C, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      frame(8'h3C, 1, 0, 1'b0);

      frame(8'hC3, 1, 0, 1'b1);
      frame(8'h96, 2, 1, 1'b1);

      for (int n = 0; n < 20; n++) begin
         frame(8'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(3)), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side sequencer for the UART.
- Accepts a parallel byte through a valid/ready handshake and drives an external right-shifting shift_register, which transmits LSB first.
- Frames the byte as start, DATA_WIDTH data bits, optional parity and 1–2 stop bits, with each bit lasting OVERSAMPLE baud ticks.
- Sits between the host-side TX interface and the serial pin.

Parameters:
- DATA_WIDTH, 8: payload bits per frame (5..9).
- OVERSAMPLE, 16: baud_tick pulses per serial bit (>=2).
- PARITY_EN, 1'b0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 1'b0: 1 selects odd parity, 0 selects even. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- baud_tick  in  1  single-cycle oversample strobe
- tx_data  in  DATA_WIDTH  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept a byte
- busy  out  1  frame in progress
- tx  out  1  serial line, idle high
- sr_load  out  1  shift register parallel load
- sr_shift  out  1  shift register shift enable
- sr_data_p  out  DATA_WIDTH  parallel load value (equals tx_data)
- sr_data_in_s  out  1  serial fill bit, tied 1
- sr_data_out_s  in  1  shift register serial output (bit 0)

Behaviour:
- Reset and clock are fixed: one clock, clk. rst is synchronous and active-high.
- Reset state: state=IDLE, tick_cnt=0, bit_cnt=0, parity_q=0.
- Outputs during reset: tx=1, tx_ready=1, busy=0, sr_load=0, sr_shift=0.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready = (state==IDLE). busy = !tx_ready.
- Accept occurs when tx_valid && tx_ready.
  - sr_load = accept (combinational). sr_data_p = tx_data.
  - At the accept edge: state<=START, tick_cnt<=0, bit_cnt<=0, parity_q<=^tx_data ^ PARITY_ODD.
- tick_cnt advances only on baud_tick.
  - bit_end = baud_tick && tick_cnt==OVERSAMPLE-1.
  - tick_cnt wraps to 0 on bit_end.
  - A baud_tick in the accept cycle is ignored.
- tx by state (mux of registered state; no logic after the mux):
  - IDLE=1, START=0, DATA=sr_data_out_s, PARITY=parity_q, STOP=1.
- Transitions on bit_end:
  - START -> DATA.
  - DATA: sr_shift=1 (exactly one cycle, DATA_WIDTH pulses per frame), bit_cnt++. When bit_cnt==DATA_WIDTH-1, go to PARITY if PARITY_EN, else STOP, and clear bit_cnt.
  - PARITY -> STOP.
  - STOP: bit_cnt++. When bit_cnt==STOP_BITS-1, go to IDLE.
- sr_load and sr_shift are never asserted in the same cycle.
- Frame length is (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*OVERSAMPLE baud ticks.
- tx_ready rises the cycle after the final bit_end.
  - Back-to-back frames: tx_valid held high is accepted in that first IDLE cycle, so the line is high for exactly 1 clk between frames.
- tx_valid/tx_data while busy are ignored and not buffered. The host must hold them until tx_ready.
- rst mid-frame: next cycle is IDLE with tx=1. The partial frame is abandoned and shift register contents are don't-care.
- bit_cnt width is $clog2(DATA_WIDTH+1). tick_cnt width is $clog2(OVERSAMPLE).

Decomposition:
- uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for idle line level (1) and start level (0);
  - a frame-length helper function.
- One natural sub-module: baud_tick_counter, the modulo-OVERSAMPLE counter with bit_end output, reusable by the RX controller.
- shift_register is instantiated by the parent with SHIFT_LEFT=0, not inside this block.

Test Plan:
1. OVERSAMPLE=4, baud_tick=1 every cycle, PARITY_EN=0, STOP_BITS=1, send 0xA5:
   - tx bits 0,1,0,1,0,0,1,0,1,1, each 4 clk wide;
   - sr_load 1 pulse, sr_shift 8 pulses;
   - tx_ready returns 41 clk after accept.
2. PARITY_EN=1 with 0xA5: even parity bit=0; PARITY_ODD=1 gives 1. 0x01 even gives 1. Frame is 44 clk.
3. STOP_BITS=2, 0xFF: stop high for 8 clk. tx_valid held high gives a second start bit exactly 1 clk after tx_ready rises.
4. baud_tick every 3rd clk, OVERSAMPLE=4: each bit lasts 12 clk. A baud_tick coincident with accept does not shorten the start bit.
5. rst asserted during the 3rd data bit: next cycle tx=1, tx_ready=1, busy=0. A new 0x3C sent afterwards frames correctly.
6. tx_valid toggled with changing tx_data while busy: no extra sr_load, and the transmitted byte equals the one accepted.
